// File: rtl/cpu_mem_slv.sv
// rtl/cpu_mem_slv.sv - AXI slave backed by NUM_WORDS x 128-bit registers, INCR bursts of 16-byte beats
// Optional CPU_MEM_SLV_DECERR_EN: out-of-window beats return DECERR instead of aliasing.
module cpu_mem_slv #(
  parameter int          NUM_WORDS = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic         ACLK,
  input  logic         ARESETn,
  input  logic [31:0]  AWADDR,
  input  logic [7:0]   AWID,
  input  logic [3:0]   AWSIZE,
  input  logic [3:0]   AWLEN,
  input  logic         AWVALID,
  output logic         AWREADY,
  input  logic [127:0] WDATA,
  input  logic [15:0]  WSTRB,
  input  logic         WLAST,
  input  logic         WVALID,
  output logic         WREADY,
  output logic [7:0]   BID,
  output logic [1:0]   BRESP,
  output logic         BVALID,
  input  logic         BREADY,
  input  logic [31:0]  ARADDR,
  input  logic [7:0]   ARID,
  input  logic [3:0]   ARSIZE,
  input  logic [3:0]   ARLEN,
  input  logic         ARVALID,
  output logic         ARREADY,
  output logic [7:0]   RID,
  output logic [127:0] RDATA,
  output logic [1:0]   RRESP,
  output logic         RLAST,
  output logic         RVALID,
  input  logic         RREADY
);

  localparam int          AW          = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [3:0]  SIZE_16B    = 4'd4;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
`ifdef CPU_MEM_SLV_DECERR_EN
  localparam logic [31:0] SPAN        = 32'(NUM_WORDS * 16);
  localparam logic [1:0]  RESP_DECERR = 2'b11;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  logic [127:0] mem [NUM_WORDS];

  // BASE_ADDR is window-aligned, so the index is just the low word-address bits of the offset
  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 4);
  endfunction

`ifdef CPU_MEM_SLV_DECERR_EN
  function automatic logic in_range(input logic [31:0] a);
    return (a - BASE_ADDR) < SPAN;
  endfunction
`endif

  // ---------------- write path ----------------
  w_state_t    w_state, w_next;
  logic [31:0] w_addr;
  logic [7:0]  w_id;
  logic [3:0]  w_len;
  logic [3:0]  w_size;
  logic [3:0]  w_cnt;
  logic        w_slverr;
  logic        w_decerr;
  logic        w_last_beat;
  logic        aw_hs;
  logic        w_hs;
  logic        w_write_en;

  assign aw_hs       = AWVALID & AWREADY;
  assign w_hs        = WVALID & WREADY;
  assign w_last_beat = (w_cnt == w_len);
  assign BID         = w_id;

`ifdef CPU_MEM_SLV_DECERR_EN
  assign w_write_en = w_hs && (w_size == SIZE_16B) && in_range(w_addr);
`else
  assign w_write_en = w_hs && (w_size == SIZE_16B);
`endif

  always_comb begin
    w_next  = w_state;
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    BRESP   = RESP_OKAY;
    case (w_state)
      W_IDLE: begin
        AWREADY = 1'b1;
        if (AWVALID) w_next = W_DATA;
      end
      W_DATA: begin
        WREADY = 1'b1;
        if (WVALID && w_last_beat) w_next = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        if (w_slverr || (w_size != SIZE_16B)) BRESP = RESP_SLVERR;
`ifdef CPU_MEM_SLV_DECERR_EN
        else if (w_decerr)                   BRESP = RESP_DECERR;
`endif
        if (BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state  <= W_IDLE;
      w_addr   <= '0;
      w_id     <= '0;
      w_len    <= '0;
      w_size   <= '0;
      w_cnt    <= '0;
      w_slverr <= 1'b0;
      w_decerr <= 1'b0;
    end else begin
      w_state <= w_next;
      if (aw_hs) begin
        w_addr   <= AWADDR;
        w_id     <= AWID;
        w_len    <= AWLEN;
        w_size   <= AWSIZE;
        w_cnt    <= '0;
        w_slverr <= 1'b0;
        w_decerr <= 1'b0;
      end
      if (w_hs) begin
        w_addr <= w_addr + 32'd16;
        w_cnt  <= w_cnt + 4'd1;
        if (WLAST != w_last_beat) w_slverr <= 1'b1;
`ifdef CPU_MEM_SLV_DECERR_EN
        if (!in_range(w_addr)) w_decerr <= 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < NUM_WORDS; i++) mem[i] <= '0;
    end else if (w_write_en) begin
      for (int b = 0; b < 16; b++) begin
        if (WSTRB[b]) mem[word_idx(w_addr)][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  r_state_t     r_state, r_next;
  logic [31:0]  r_addr;
  logic [3:0]   r_len;
  logic [3:0]   r_size;
  logic [3:0]   r_cnt;
  logic         ar_hs;
  logic         r_hs;
  logic         fetch_en;
  logic [31:0]  fetch_addr;
  logic [3:0]   fetch_size;
  logic [127:0] fetch_data;
  logic [1:0]   fetch_resp;

  assign ar_hs = ARVALID & ARREADY;
  assign r_hs  = RVALID & RREADY;

  always_comb begin
    r_next  = r_state;
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    RLAST   = 1'b0;
    case (r_state)
      R_IDLE: begin
        ARREADY = 1'b1;
        if (ARVALID) r_next = R_DATA;
      end
      R_DATA: begin
        RVALID = 1'b1;
        RLAST  = (r_cnt == r_len);
        if (RREADY && (r_cnt == r_len)) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Each beat is sampled into RDATA on the edge that starts its presentation, so it
  // holds through stalls and a same-edge write to that word is not seen.
  assign fetch_en   = ar_hs | (r_hs & ~RLAST);
  assign fetch_addr = (r_state == R_IDLE) ? ARADDR : (r_addr + 32'd16);
  assign fetch_size = (r_state == R_IDLE) ? ARSIZE : r_size;

  always_comb begin
    fetch_data = '0;
    fetch_resp = RESP_OKAY;
    if (fetch_size != SIZE_16B) begin
      fetch_resp = RESP_SLVERR;
`ifdef CPU_MEM_SLV_DECERR_EN
    end else if (!in_range(fetch_addr)) begin
      fetch_resp = RESP_DECERR;
`endif
    end else begin
      fetch_data = mem[word_idx(fetch_addr)];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_cnt   <= '0;
      RID     <= '0;
      RDATA   <= '0;
      RRESP   <= RESP_OKAY;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        r_addr <= ARADDR;
        r_len  <= ARLEN;
        r_size <= ARSIZE;
        r_cnt  <= '0;
        RID    <= ARID;
      end
      if (r_hs) begin
        r_addr <= r_addr + 32'd16;
        r_cnt  <= r_cnt + 4'd1;
      end
      if (fetch_en) begin
        RDATA <= fetch_data;
        RRESP <= fetch_resp;
      end
    end
  end

endmodule

// File: tb/tb_cpu_mem_slv.sv
// tb/tb_cpu_mem_slv.sv - directed table-driven bench for cpu_mem_slv
module tb_cpu_mem_slv;

  logic         ACLK = 1'b0;
  logic         ARESETn = 1'b0;
  logic [31:0]  AWADDR = '0;
  logic [7:0]   AWID = '0;
  logic [3:0]   AWSIZE = '0;
  logic [3:0]   AWLEN = '0;
  logic         AWVALID = 1'b0;
  logic         AWREADY;
  logic [127:0] WDATA = '0;
  logic [15:0]  WSTRB = '0;
  logic         WLAST = 1'b0;
  logic         WVALID = 1'b0;
  logic         WREADY;
  logic [7:0]   BID;
  logic [1:0]   BRESP;
  logic         BVALID;
  logic         BREADY = 1'b0;
  logic [31:0]  ARADDR = '0;
  logic [7:0]   ARID = '0;
  logic [3:0]   ARSIZE = '0;
  logic [3:0]   ARLEN = '0;
  logic         ARVALID = 1'b0;
  logic         ARREADY;
  logic [7:0]   RID;
  logic [127:0] RDATA;
  logic [1:0]   RRESP;
  logic         RLAST;
  logic         RVALID;
  logic         RREADY = 1'b0;

  always #5 ACLK = ~ACLK;

  cpu_mem_slv #(.NUM_WORDS(16), .BASE_ADDR(32'h0000_0000)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWID(AWID), .AWSIZE(AWSIZE), .AWLEN(AWLEN),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARID(ARID), .ARSIZE(ARSIZE), .ARLEN(ARLEN),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  localparam logic [127:0] DA = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] DB = 128'hB0B1_B2B3_B4B5_B6B7_B8B9_BABB_BCBD_BE00;
  localparam logic [127:0] DC = 128'hC0C0_C0C0_C0C0_C0C0_C0C0_C0C0_C0C0_C0C0;
  localparam logic [127:0] DD = 128'hDDDD_DDDD_DDDD_DDDD_DDDD_DDDD_CAFE_F00D;
  localparam logic [127:0] DD_LO = 128'h0000_0000_0000_0000_0000_0000_CAFE_F00D;
  localparam logic [127:0] DE = 128'hE000_0000_0000_0000_0000_0000_0000_0E00;
  localparam logic [127:0] DF = 128'hF00F_F00F_F00F_F00F_F00F_F00F_F00F_F000;
  localparam logic [127:0] DG = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3200;
  localparam logic [127:0] DH = 128'h5A5A_5A5A_A5A5_A5A5_5A5A_5A5A_A5A5_A5A5;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string what);
    total++;
    bad++;
    $display("FAIL timeout %s", what);
  endtask

  logic [127:0] rd_data [16];
  logic [1:0]   rd_resp [16];
  logic         rd_last [16];
  logic [7:0]   rd_id   [16];
  int           rd_gap  [16];

  task automatic axi_write(input logic [31:0] a, input logic [7:0] id, input logic [3:0] len,
                           input logic [3:0] size, input logic [127:0] d0, input logic [15:0] strb,
                           input int last_beat, output logic [1:0] resp, output logic [7:0] bid,
                           output int bwait);
    int n;
    AWADDR = a; AWID = id; AWLEN = len; AWSIZE = size; AWVALID = 1'b1;
    n = 0;
    while (!AWREADY && n < 50) begin @(negedge ACLK); n++; end
    if (n >= 50) timeout("aw");
    @(negedge ACLK);
    AWVALID = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      WDATA = d0 + 128'(b); WSTRB = strb; WLAST = (b == last_beat); WVALID = 1'b1;
      n = 0;
      while (!WREADY && n < 50) begin @(negedge ACLK); n++; end
      if (n >= 50) timeout("w");
      @(negedge ACLK);
    end
    WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
    bwait = 0;
    while (!BVALID && bwait < 50) begin @(negedge ACLK); bwait++; end
    if (bwait >= 50) timeout("b");
    resp = BRESP;
    bid  = BID;
    @(negedge ACLK);
    BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [7:0] id, input logic [3:0] len,
                          input logic [3:0] size);
    int n;
    ARADDR = a; ARID = id; ARLEN = len; ARSIZE = size; ARVALID = 1'b1;
    n = 0;
    while (!ARREADY && n < 50) begin @(negedge ACLK); n++; end
    if (n >= 50) timeout("ar");
    @(negedge ACLK);
    ARVALID = 1'b0; RREADY = 1'b1;
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      while (!RVALID && n < 50) begin @(negedge ACLK); n++; end
      if (n >= 50) timeout("r");
      rd_gap[b] = n; rd_data[b] = RDATA; rd_resp[b] = RRESP; rd_last[b] = RLAST; rd_id[b] = RID;
      @(negedge ACLK);
    end
    RREADY = 1'b0;
  endtask

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [7:0]   id;
    logic [3:0]   len;
    logic [3:0]   size;
    logic [127:0] data;
    logic [15:0]  strb;
    int           last_beat;
    logic [1:0]   exp_resp;
    logic [127:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [1:0] resp;
    logic [7:0] bid;
    int         bwait;

    vecs.push_back('{1'b1, 32'h10, 8'd5, 4'd0, 4'd4, DA, 16'hFFFF, 0, 2'b00, '0});
    vecs.push_back('{1'b0, 32'h10, 8'd7, 4'd0, 4'd4, '0, '0, 0, 2'b00, DA});
    vecs.push_back('{1'b1, 32'h40, 8'd1, 4'd1, 4'd4, DB, 16'hFFFF, 0, 2'b10, '0});
    vecs.push_back('{1'b0, 32'h40, 8'd2, 4'd0, 4'd4, '0, '0, 0, 2'b00, DB});
    vecs.push_back('{1'b0, 32'h50, 8'd2, 4'd0, 4'd4, '0, '0, 0, 2'b00, DB + 128'd1});
    vecs.push_back('{1'b1, 32'h60, 8'd9, 4'd0, 4'd2, DC, 16'hFFFF, 0, 2'b10, '0});
    vecs.push_back('{1'b0, 32'h60, 8'd9, 4'd0, 4'd4, '0, '0, 0, 2'b00, '0});
    vecs.push_back('{1'b1, 32'h70, 8'd3, 4'd0, 4'd4, DD, 16'h000F, 0, 2'b00, '0});
    vecs.push_back('{1'b0, 32'h70, 8'd3, 4'd0, 4'd4, '0, '0, 0, 2'b00, DD_LO});
    vecs.push_back('{1'b0, 32'h70, 8'd3, 4'd0, 4'd3, '0, '0, 0, 2'b10, '0});
    vecs.push_back('{1'b1, 32'h80, 8'd4, 4'd1, 4'd4, DE, 16'hFFFF, 5, 2'b10, '0});
    vecs.push_back('{1'b0, 32'h90, 8'd4, 4'd0, 4'd4, '0, '0, 0, 2'b00, DE + 128'd1});
`ifdef CPU_MEM_SLV_DECERR_EN
    vecs.push_back('{1'b1, 32'hF0, 8'd6, 4'd1, 4'd4, DF, 16'hFFFF, 1, 2'b11, '0});
    vecs.push_back('{1'b0, 32'h100, 8'd6, 4'd0, 4'd4, '0, '0, 0, 2'b11, '0});
`else
    vecs.push_back('{1'b1, 32'hF0, 8'd6, 4'd1, 4'd4, DF, 16'hFFFF, 1, 2'b00, '0});
    vecs.push_back('{1'b0, 32'h100, 8'd6, 4'd0, 4'd4, '0, '0, 0, 2'b00, DF + 128'd1});
`endif
    vecs.push_back('{1'b0, 32'hF0, 8'd6, 4'd0, 4'd4, '0, '0, 0, 2'b00, DF});

    // reset state, sampled while reset is held
    @(negedge ACLK);
    @(negedge ACLK);
    check("rst_awready", 128'(AWREADY), 128'd1);
    check("rst_arready", 128'(ARREADY), 128'd1);
    check("rst_wready",  128'(WREADY),  128'd0);
    check("rst_bvalid",  128'(BVALID),  128'd0);
    check("rst_rvalid",  128'(RVALID),  128'd0);
    check("rst_rlast",   128'(RLAST),   128'd0);
    check("rst_ids",     128'({BID, RID}), 128'd0);
    check("rst_resps",   128'({BRESP, RRESP}), 128'd0);
    check("rst_rdata",   RDATA, 128'd0);
    ARESETn = 1'b1;
    @(negedge ACLK);

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].id, vecs[i].len, vecs[i].size, vecs[i].data,
                  vecs[i].strb, vecs[i].last_beat, resp, bid, bwait);
        check($sformatf("v%0d_bresp", i), 128'(resp), 128'(vecs[i].exp_resp));
        check($sformatf("v%0d_bid", i), 128'(bid), 128'(vecs[i].id));
        check($sformatf("v%0d_bwait", i), 128'(bwait), 128'd0);
      end else begin
        axi_read(vecs[i].addr, vecs[i].id, vecs[i].len, vecs[i].size);
        check($sformatf("v%0d_rdata", i), rd_data[0], vecs[i].exp_data);
        check($sformatf("v%0d_rresp", i), 128'(rd_resp[0]), 128'(vecs[i].exp_resp));
        check($sformatf("v%0d_rid", i), 128'(rd_id[0]), 128'(vecs[i].id));
        check($sformatf("v%0d_rlast", i), 128'(rd_last[vecs[i].len]), 128'd1);
        check($sformatf("v%0d_rgap", i), 128'(rd_gap[0]), 128'd0);
      end
    end

    // 4-beat burst fill and back-to-back read of words 0..3
    axi_write(32'h0, 8'd8, 4'd3, 4'd4, DG, 16'hFFFF, 3, resp, bid, bwait);
    check("burst_w_bresp", 128'(resp), 128'd0);
    axi_read(32'h0, 8'd3, 4'd3, 4'd4);
    for (int b = 0; b < 4; b++) begin
      check($sformatf("burst_r%0d_data", b), rd_data[b], DG + 128'(b));
      check($sformatf("burst_r%0d_last", b), 128'(rd_last[b]), 128'(b == 3));
      check($sformatf("burst_r%0d_id", b), 128'(rd_id[b]), 128'd3);
      check($sformatf("burst_r%0d_gap", b), 128'(rd_gap[b]), 128'd0);
    end

    // RREADY stall mid-burst
    ARADDR = 32'h0; ARID = 8'h11; ARLEN = 4'd3; ARSIZE = 4'd4; ARVALID = 1'b1;
    @(negedge ACLK);
    ARVALID = 1'b0; RREADY = 1'b1;
    check("stall_b0_data", RDATA, DG);
    @(negedge ACLK);
    RREADY = 1'b0;
    check("stall_b1_data", RDATA, DG + 128'd1);
    for (int c = 0; c < 2; c++) begin
      @(negedge ACLK);
      check($sformatf("stall_hold%0d_data", c), RDATA, DG + 128'd1);
      check($sformatf("stall_hold%0d_last", c), 128'(RLAST), 128'd0);
      check($sformatf("stall_hold%0d_valid", c), 128'(RVALID), 128'd1);
    end
    RREADY = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);
    check("stall_b3_data", RDATA, DG + 128'd3);
    check("stall_b3_last", 128'(RLAST), 128'd1);
    @(negedge ACLK);
    RREADY = 1'b0;
    check("stall_done_valid", 128'(RVALID), 128'd0);

    // write and read beats to word 2 in the same cycle
    AWADDR = 32'h20; AWID = 8'h21; AWLEN = 4'd0; AWSIZE = 4'd4; AWVALID = 1'b1;
    ARADDR = 32'h20; ARID = 8'h22; ARLEN = 4'd0; ARSIZE = 4'd4; ARVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0; ARVALID = 1'b0;
    WDATA = DH; WSTRB = 16'hFFFF; WLAST = 1'b1; WVALID = 1'b1; RREADY = 1'b1;
    check("coll_wready", 128'(WREADY), 128'd1);
    check("coll_rvalid", 128'(RVALID), 128'd1);
    check("coll_rdata_old", RDATA, DG + 128'd2);
    @(negedge ACLK);
    WVALID = 1'b0; WLAST = 1'b0; RREADY = 1'b0; BREADY = 1'b1;
    check("coll_bvalid", 128'(BVALID), 128'd1);
    check("coll_bresp", 128'(BRESP), 128'd0);
    @(negedge ACLK);
    BREADY = 1'b0;
    axi_read(32'h20, 8'h23, 4'd0, 4'd4);
    check("coll_readback", rd_data[0], DH);

    // reset during beat 2 of a 4-beat read
    ARADDR = 32'h0; ARID = 8'h31; ARLEN = 4'd3; ARSIZE = 4'd4; ARVALID = 1'b1;
    @(negedge ACLK);
    ARVALID = 1'b0; RREADY = 1'b1;
    @(negedge ACLK);
    check("mid_b1_data", RDATA, DG + 128'd1);
    ARESETn = 1'b0;
    #1;
    check("mid_rst_rvalid", 128'(RVALID), 128'd0);
    check("mid_rst_arready", 128'(ARREADY), 128'd1);
    check("mid_rst_rlast", 128'(RLAST), 128'd0);
    check("mid_rst_rdata", RDATA, 128'd0);
    RREADY = 1'b0;
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("post_rst_rvalid", 128'(RVALID), 128'd0);
    axi_read(32'h0, 8'h32, 4'd3, 4'd4);
    for (int b = 0; b < 4; b++) begin
      check($sformatf("post_rst_w%0d", b), rd_data[b], 128'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
